// File: rtl/fifo_write_ctrl.sv
// Write-side front end of the async FIFO: a two-word skid buffer feeding one write per cycle,
// a read-pointer synchroniser, fill level / almost_full, and an accepted-write counter.
module fifo_write_ctrl #(
  parameter int ADDBITS      = 2,
  parameter int WIDTH        = ADDBITS + 1,
  parameter int DWIDTH       = 8,
  parameter int AFULL_THRESH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  rpointer_async,
  input  logic [WIDTH-1:0]  wpointer,
  input  logic              full,
  output logic              count,
  output logic [DWIDTH-1:0] wdata,
  output logic [WIDTH-1:0]  rpointer_sync,
  output logic [WIDTH-1:0]  level,
  output logic              almost_full,
  output logic [15:0]       wr_total
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam logic [WIDTH-1:0] THRESH = WIDTH'(AFULL_THRESH);

  logic [1:0]        state;
  logic [DWIDTH-1:0] main_q;
  logic [DWIDTH-1:0] skid_q;
  logic [WIDTH-1:0]  sync1;
  logic              accept;
  logic              pop;
  logic [WIDTH-1:0]  wbin;
  logic [WIDTH-1:0]  rbin;
  logic [WIDTH-1:0]  level_next;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Ready and write strobe depend only on held state, so s_valid never reaches count.
  assign s_ready = (state != TWO);
  assign count   = (state != EMPTY) & ~full;
  assign wdata   = main_q;
  assign accept  = s_valid & s_ready;
  assign pop     = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= s_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= s_data;
          end else if (accept) begin
            skid_q <= s_data;
            state  <= TWO;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      rpointer_sync <= '0;
    end else begin
      sync1         <= rpointer_async;
      rpointer_sync <= sync1;
    end
  end

  // Modular subtraction handles pointer wrap; the stale synced read pointer only over-reports.
  assign wbin       = gray2bin(wpointer);
  assign rbin       = gray2bin(rpointer_sync);
  assign level_next = wbin - rbin;

  always_ff @(posedge clk) begin
    if (rst) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_next;
      almost_full <= (level_next >= THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_total <= '0;
    end else if (count) begin
      wr_total <= wr_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl: queue-based reference model checked every cycle,
// plus literal expectations for the listed scenarios.
module tb_fifo_write_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [2:0] rpointer_async;
  logic [2:0] wpointer;
  logic       full;
  logic       count;
  logic [7:0] wdata;
  logic [2:0] rpointer_sync;
  logic [2:0] level;
  logic       almost_full;
  logic [15:0] wr_total;

  fifo_write_ctrl dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rpointer_async(rpointer_async), .wpointer(wpointer), .full(full),
    .count(count), .wdata(wdata), .rpointer_sync(rpointer_sync), .level(level),
    .almost_full(almost_full), .wr_total(wr_total)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [2:0] g2b(input logic [2:0] g);
    logic [2:0] b;
    b = g;
    for (int s = 1; s < 3; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Reference model: words held = queue, sync = two-deep history of rpointer_async.
  logic [7:0]  mq[$];
  logic [2:0]  m_s1, m_rs, m_lvl;
  logic        m_af;
  logic [15:0] m_tot;

  always @(posedge clk) begin
    bit pop_m, acc_m;
    if (rst) begin
      mq.delete();
      m_s1 = '0; m_rs = '0; m_lvl = '0; m_af = 1'b0; m_tot = '0;
    end else begin
      pop_m = (mq.size() > 0) && !full;
      acc_m = s_valid && (mq.size() < 2);
      if (pop_m) begin
        void'(mq.pop_front());
        m_tot = m_tot + 16'd1;
      end
      if (acc_m) mq.push_back(s_data);
      m_lvl = g2b(wpointer) - g2b(m_rs);
      m_af  = (m_lvl >= 3'd3);
      m_rs  = m_s1;
      m_s1  = rpointer_async;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("s_ready", {31'd0, s_ready}, {31'd0, mq.size() < 2});
      chk("count", {31'd0, count}, {31'd0, (mq.size() > 0) && !full});
      if (mq.size() > 0 && !full) chk("wdata", {24'd0, wdata}, {24'd0, mq[0]});
      chk("rpointer_sync", {29'd0, rpointer_sync}, {29'd0, m_rs});
      chk("level", {29'd0, level}, {29'd0, m_lvl});
      chk("almost_full", {31'd0, almost_full}, {31'd0, m_af});
      chk("wr_total", {16'd0, wr_total}, {16'd0, m_tot});
    end
  end

  // Log of words actually written by the DUT, with cycle stamps.
  logic [7:0] wlog[$];
  int         wcyc[$];
  int         cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst && count) begin
      wlog.push_back(wdata);
      wcyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp1[3];
    logic [2:0] gseq[5];
    rst = 1'b1; s_valid = 1'b0; s_data = '0; full = 1'b0;
    wpointer = '0; rpointer_async = '0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_total", {16'd0, wr_total}, 32'd0);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_count", {31'd0, count}, 32'd0);

    // 1: three words back to back
    wlog.delete(); wcyc.delete();
    s_valid = 1'b1; s_data = 8'h11; step();
    chk("t1_first_count", {31'd0, count}, 32'd1);
    chk("t1_first_wdata", {24'd0, wdata}, 32'h11);
    s_data = 8'h22; step();
    s_data = 8'h33; step();
    s_valid = 1'b0; step(); step();
    exp1 = '{8'h11, 8'h22, 8'h33};
    chk("t1_nwrites", wlog.size(), 32'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("t1_order", {24'd0, wlog[i]}, {24'd0, exp1[i]});
    chk("t1_total", {16'd0, wr_total}, 32'd3);

    // 2: full stall, fill skid, then drain
    wlog.delete(); wcyc.delete();
    full = 1'b1;
    s_valid = 1'b1; s_data = 8'hA1; step();
    s_data = 8'hA2; step();
    chk("t2_ready_low", {31'd0, s_ready}, 32'd0);
    s_data = 8'hEE; step();
    s_data = 8'hA3; step();
    chk("t2_count_held", {31'd0, count}, 32'd0);
    full = 1'b0; #1;
    chk("t2_resume_count", {31'd0, count}, 32'd1);
    chk("t2_resume_wdata", {24'd0, wdata}, 32'hA1);
    step();
    step();
    s_valid = 1'b0; step(); step();
    exp1 = '{8'hA1, 8'hA2, 8'hA3};
    chk("t2_nwrites", wlog.size(), 32'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("t2_order", {24'd0, wlog[i]}, {24'd0, exp1[i]});
    if (wcyc.size() == 3) chk("t2_consecutive", wcyc[2] - wcyc[0], 32'd2);

    // 3: level ramp with read pointer at zero
    full = 1'b1;
    gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
    for (int i = 0; i < 5; i++) begin
      wpointer = gseq[i];
      step();
      if (i == 0) step();
      chk("t3_level", {29'd0, level}, i);
      chk("t3_afull", {31'd0, almost_full}, {31'd0, i >= 3});
    end

    // 4: wrapped pointers, visible after sync plus register
    wpointer = 3'b001; rpointer_async = 3'b101;
    step(); step();
    chk("t4_level_lag", {29'd0, level}, 32'd1);
    step();
    chk("t4_level_wrap", {29'd0, level}, 32'd3);
    chk("t4_afull_wrap", {31'd0, almost_full}, 32'd1);

    // 5: reset while holding two words
    wlog.delete(); wcyc.delete();
    s_valid = 1'b1; s_data = 8'hB1; step();
    s_data = 8'hB2; step();
    chk("t5_ready_low", {31'd0, s_ready}, 32'd0);
    rst = 1'b1; full = 1'b0; s_valid = 1'b0; wpointer = '0; rpointer_async = '0;
    step();
    chk("t5_count", {31'd0, count}, 32'd0);
    chk("t5_level", {29'd0, level}, 32'd0);
    chk("t5_total", {16'd0, wr_total}, 32'd0);
    rst = 1'b0;
    step(); step();
    chk("t5_nothing_written", wlog.size(), 32'd0);

    // 6: counter wrap
    s_valid = 1'b1;
    for (int i = 0; i < 16'hFFFE; i++) begin
      s_data = i[7:0];
      step();
    end
    s_valid = 1'b0; step();
    chk("t6_total_fffe", {16'd0, wr_total}, 32'h0000FFFE);
    s_valid = 1'b1; step();
    s_valid = 1'b0; step();
    chk("t6_total_ffff", {16'd0, wr_total}, 32'h0000FFFF);
    s_valid = 1'b1; step();
    s_valid = 1'b0; step();
    chk("t6_total_wrap", {16'd0, wr_total}, 32'd0);
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
